core_wb_stage: RTL and testbench
================================

# core_wb_stage

Write-back stage of the RV32I core, directly downstream of the memory stage. Consumes the registered W-side signals: ALU result, destination register, write enable, load flag, load op and raw read word. Extracts and extends load data, and drives the register-file write port. Stalls the pipeline while a load's read data has not yet returned (`data_rvalid_i` late). Keeps a one-entry forwarding register and a retired-write counter.

## Interface
- `DATA_WIDTH`, 32: datapath width.
- `REG_ADDR_WIDTH`, 5: register address width.
- `CNT_WIDTH`, 32: retired-write counter width.

- `clk`  in  1  clock; the reset is asynchronous, active-low, named `rst_n`.
- `rst_n`  in  1  asynchronous active-low reset.
- `w_regfile_waddr_i`  in  5  destination register.
- `w_regfile_rd_i`  in  32  ALU/forwarded result for non-load writes.
- `w_regfile_wr_i`  in  1  instruction writes a register.
- `w_is_load_store_i`  in  1  instruction is a load or store.
- `w_LOAD_op_i`  in  3  funct3 of the load.
- `w_addr_lsb_i`  in  2  byte offset of the load address, registered by the memory stage.
- `w_data_rdata_i`  in  32  raw word from data memory.
- `data_rvalid_i`  in  1  read data valid.
- `rf_waddr_o`  out  5  register-file write address.
- `rf_wdata_o`  out  32  register-file write data.
- `rf_we_o`  out  1  register-file write enable.
- `stall_o`  out  1  freeze upstream stages.
- `fwd_valid_o`, `fwd_addr_o`, `fwd_data_o`  out  1/5/32  last committed write.
- `instret_o`  out  CNT_WIDTH  count of committed register writes.

## Operation
- A load is `w_is_load_store_i & w_regfile_wr_i`; a store (`wr=0`) never writes.
- Non-load write: `rf_we_o=w_regfile_wr_i`, `rf_wdata_o=w_regfile_rd_i`, `rf_waddr_o=w_regfile_waddr_i`.
- Load data extraction:
  - LB 000 / LBU 100: byte `rdata[8*lsb+:8]`, sign- or zero-extended.
  - LH 001 / LHU 101: half `rdata[16*lsb[1]+:16]`, sign- or zero-extended; `lsb[0]` is ignored.
  - LW 010 and any other code: full word.
- Writes to x0 are suppressed: `rf_we_o=0`, no counter or forward update.
- FSM states:
  - IDLE:
    - Load with `data_rvalid_i=1`: commit the extracted data this cycle and stay in IDLE.
    - Load with `data_rvalid_i=0`: capture waddr, op and lsb, assert `stall_o` combinationally this cycle, and go to WAIT.
    - `data_rvalid_i` without a load is ignored.
  - WAIT:
    - `stall_o=1` and `rf_we_o=0` until `data_rvalid_i`.
    - On `data_rvalid_i`: commit from the captured fields plus the current `w_data_rdata_i`, drop `stall_o` that same cycle, and go to IDLE.
    - Pipeline inputs other than rdata/rvalid are ignored in WAIT, because upstream is frozen.
- Each commit with `rf_we_o=1`:
  - On the next edge, `fwd_valid_o<=1`, `fwd_addr_o<=addr`, `fwd_data_o<=data`.
  - `instret_o` increments, wrapping at 2^CNT_WIDTH.

## Timing
- Reset values: state IDLE; `stall_o=0`, `rf_we_o=0`, `rf_waddr_o=0`, `rf_wdata_o=0`; `fwd_valid_o=0`, `fwd_addr_o=0`, `fwd_data_o=0`; `instret_o=0`.
- Write port is combinational in the same cycle the instruction is presented. The register file samples it on the next clk edge.
- Forward and counter outputs have 1-cycle latency after a commit.
- Load stall length is exactly the number of cycles until `data_rvalid_i`. A load with immediate rvalid adds 0 cycles.
- Reset asserted in WAIT: abort the pending load, with no write, returning to IDLE and `stall_o=0` asynchronously.
- Back-to-back loads: the second load is evaluated in IDLE on the cycle after the first commit.

## Structure
- `defines.vh` holds `DATA_WIDTH`, `REG_ADDR_WIDTH`, `LOAD_OP_WIDTH`, and the load codes `LB/LH/LW/LBU/LHU`.
- The memory stage gains a registered `w_addr_lsb_o` output.
- Sub-module `core_load_extend` is purely combinational: `(op, lsb, rdata) -> wdata`. It is instantiated once and fed by a mux of live inputs and WAIT-captured fields.

## Test plan
- ALU write: x5 with data 0x1234_5678 -> `rf_we_o=1` same cycle; next cycle `fwd_addr_o=5`, `fwd_data_o=0x12345678`, `instret_o=1`.
- LB, lsb=3, rdata 0x80FF_0000, rvalid immediate -> wdata 0xFFFF_FF80, no stall. The same case with LBU -> 0x0000_0080.
- LH, lsb=2, rdata 0x8001_7FFF, rvalid 3 cycles late -> `stall_o` high 3 cycles, one write of 0xFFFF_8001 on the rvalid cycle, `stall_o` low that cycle.
- Write to x0 (ALU or load) -> `rf_we_o=0`, `instret_o` unchanged, `fwd_valid_o` unchanged.
- Store (`is_load_store=1`, `wr=0`) with rvalid pulses -> no write, no stall.
- `rst_n` low during WAIT -> `stall_o=0` immediately, no write; a later rvalid is ignored.

Source files
------------

// File: rtl/core_wb_stage_pkg.sv
// Shared constants and types for the RV32I write-back stage.
package core_wb_stage_pkg;

  localparam int unsigned LOAD_OP_WIDTH = 3;
  localparam int unsigned XLEN          = 32;
  localparam int unsigned RADDR_W       = 5;

  localparam logic [LOAD_OP_WIDTH-1:0] LB  = 3'b000;
  localparam logic [LOAD_OP_WIDTH-1:0] LH  = 3'b001;
  localparam logic [LOAD_OP_WIDTH-1:0] LW  = 3'b010;
  localparam logic [LOAD_OP_WIDTH-1:0] LBU = 3'b100;
  localparam logic [LOAD_OP_WIDTH-1:0] LHU = 3'b101;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  // Load fields held while waiting for late read data.
  typedef struct packed {
    logic [RADDR_W-1:0]       addr;
    logic [LOAD_OP_WIDTH-1:0] op;
    logic [1:0]               lsb;
  } load_ctx_t;

endpackage

// File: rtl/core_load_extend.sv
// Combinational load-data extraction: selects byte/half/word and extends it.
module core_load_extend
  import core_wb_stage_pkg::*;
(
  input  logic [LOAD_OP_WIDTH-1:0] op_i,
  input  logic [1:0]               lsb_i,
  input  logic [XLEN-1:0]          rdata_i,
  output logic [XLEN-1:0]          wdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{lsb_i, 3'b000} +: 8];
    half_sel = lsb_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    wdata_o  = rdata_i;
    case (op_i)
      LB:      wdata_o = {{24{byte_sel[7]}}, byte_sel};
      LBU:     wdata_o = {24'h0, byte_sel};
      LH:      wdata_o = {{16{half_sel[15]}}, half_sel};
      LHU:     wdata_o = {16'h0, half_sel};
      default: wdata_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/core_wb_stage.sv
// RV32I write-back stage: register-file write port, late-load stall,
// last-write forwarding register and retired-write counter.
module core_wb_stage
  import core_wb_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] w_regfile_waddr_i,
  input  logic [DATA_WIDTH-1:0]     w_regfile_rd_i,
  input  logic                      w_regfile_wr_i,
  input  logic                      w_is_load_store_i,
  input  logic [2:0]                w_LOAD_op_i,
  input  logic [1:0]                w_addr_lsb_i,
  input  logic [DATA_WIDTH-1:0]     w_data_rdata_i,
  input  logic                      data_rvalid_i,
  output logic [REG_ADDR_WIDTH-1:0] rf_waddr_o,
  output logic [DATA_WIDTH-1:0]     rf_wdata_o,
  output logic                      rf_we_o,
  output logic                      stall_o,
  output logic                      fwd_valid_o,
  output logic [REG_ADDR_WIDTH-1:0] fwd_addr_o,
  output logic [DATA_WIDTH-1:0]     fwd_data_o,
  output logic [CNT_WIDTH-1:0]      instret_o
);

  logic [0:0]                state_q, state_d;
  load_ctx_t                 ctx_q, ctx_d;
  logic                      fwd_valid_q, fwd_valid_d;
  logic [REG_ADDR_WIDTH-1:0] fwd_addr_q, fwd_addr_d;
  logic [DATA_WIDTH-1:0]     fwd_data_q, fwd_data_d;
  logic [CNT_WIDTH-1:0]      instret_q, instret_d;

  logic [LOAD_OP_WIDTH-1:0]  ext_op;
  logic [1:0]                ext_lsb;
  logic [DATA_WIDTH-1:0]     ext_wdata;
  logic                      is_load;
  logic                      commit;
  logic                      we;
  logic                      stall;
  logic [REG_ADDR_WIDTH-1:0] commit_addr;
  logic [DATA_WIDTH-1:0]     commit_data;

  // In WAIT the extender sees the captured load fields; upstream is frozen.
  assign ext_op  = (state_q == ST_WAIT) ? ctx_q.op  : w_LOAD_op_i;
  assign ext_lsb = (state_q == ST_WAIT) ? ctx_q.lsb : w_addr_lsb_i;
  assign is_load = w_is_load_store_i & w_regfile_wr_i;

  core_load_extend u_load_extend (
    .op_i    (ext_op),
    .lsb_i   (ext_lsb),
    .rdata_i (w_data_rdata_i),
    .wdata_o (ext_wdata)
  );

  always_comb begin
    state_d     = state_q;
    ctx_d       = ctx_q;
    fwd_valid_d = fwd_valid_q;
    fwd_addr_d  = fwd_addr_q;
    fwd_data_d  = fwd_data_q;
    instret_d   = instret_q;
    commit      = 1'b0;
    stall       = 1'b0;
    commit_addr = '0;
    commit_data = '0;

    case (state_q)
      ST_IDLE: begin
        if (is_load) begin
          if (data_rvalid_i) begin
            commit      = 1'b1;
            commit_addr = w_regfile_waddr_i;
            commit_data = ext_wdata;
          end else begin
            stall   = 1'b1;
            ctx_d   = '{addr: w_regfile_waddr_i, op: w_LOAD_op_i, lsb: w_addr_lsb_i};
            state_d = ST_WAIT;
          end
        end else if (w_regfile_wr_i && !w_is_load_store_i) begin
          commit      = 1'b1;
          commit_addr = w_regfile_waddr_i;
          commit_data = w_regfile_rd_i;
        end
      end
      ST_WAIT: begin
        if (data_rvalid_i) begin
          commit      = 1'b1;
          commit_addr = ctx_q.addr;
          commit_data = ext_wdata;
          state_d     = ST_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    we = commit && (commit_addr != '0);

    if (we) begin
      fwd_valid_d = 1'b1;
      fwd_addr_d  = commit_addr;
      fwd_data_d  = commit_data;
      instret_d   = instret_q + CNT_WIDTH'(1);
    end

    // Hold the write port and stall quiet while reset is asserted.
    if (!rst_n) begin
      we          = 1'b0;
      stall       = 1'b0;
      commit_addr = '0;
      commit_data = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ctx_q       <= '0;
      fwd_valid_q <= 1'b0;
      fwd_addr_q  <= '0;
      fwd_data_q  <= '0;
      instret_q   <= '0;
    end else begin
      state_q     <= state_d;
      ctx_q       <= ctx_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_addr_q  <= fwd_addr_d;
      fwd_data_q  <= fwd_data_d;
      instret_q   <= instret_d;
    end
  end

  assign rf_we_o     = we;
  assign rf_waddr_o  = commit_addr;
  assign rf_wdata_o  = commit_data;
  assign stall_o     = stall;
  assign fwd_valid_o = fwd_valid_q;
  assign fwd_addr_o  = fwd_addr_q;
  assign fwd_data_o  = fwd_data_q;
  assign instret_o   = instret_q;

endmodule

// File: tb/tb_core_wb_stage.sv
// Bench for core_wb_stage: directed vectors, a per-cycle reference model and literal checks.
module tb_core_wb_stage;

  logic        clk;
  logic        rst_n;
  logic [4:0]  w_regfile_waddr_i;
  logic [31:0] w_regfile_rd_i;
  logic        w_regfile_wr_i;
  logic        w_is_load_store_i;
  logic [2:0]  w_LOAD_op_i;
  logic [1:0]  w_addr_lsb_i;
  logic [31:0] w_data_rdata_i;
  logic        data_rvalid_i;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        rf_we_o;
  logic        stall_o;
  logic        fwd_valid_o;
  logic [4:0]  fwd_addr_o;
  logic [31:0] fwd_data_o;
  logic [31:0] instret_o;

  int checks = 0;
  int errors = 0;

  core_wb_stage dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .w_regfile_waddr_i (w_regfile_waddr_i),
    .w_regfile_rd_i    (w_regfile_rd_i),
    .w_regfile_wr_i    (w_regfile_wr_i),
    .w_is_load_store_i (w_is_load_store_i),
    .w_LOAD_op_i       (w_LOAD_op_i),
    .w_addr_lsb_i      (w_addr_lsb_i),
    .w_data_rdata_i    (w_data_rdata_i),
    .data_rvalid_i     (data_rvalid_i),
    .rf_waddr_o        (rf_waddr_o),
    .rf_wdata_o        (rf_wdata_o),
    .rf_we_o           (rf_we_o),
    .stall_o           (stall_o),
    .fwd_valid_o       (fwd_valid_o),
    .fwd_addr_o        (fwd_addr_o),
    .fwd_data_o        (fwd_data_o),
    .instret_o         (instret_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Load semantics by plain arithmetic on the raw word.
  function automatic logic [31:0] m_extract(input logic [2:0] op, input logic [1:0] lsb,
                                            input logic [31:0] w);
    logic [31:0] v;
    case (op)
      3'd0, 3'd4: begin
        v = (w >> (8 * lsb)) & 32'hFF;
        if (op == 3'd0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end
      3'd1, 3'd5: begin
        v = (w >> (16 * (lsb / 2))) & 32'hFFFF;
        if (op == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  // Reference model state
  bit          m_pend;
  logic [4:0]  m_addr;
  logic [2:0]  m_op;
  logic [1:0]  m_lsb;
  bit          m_fwd_v;
  logic [4:0]  m_fwd_a;
  logic [31:0] m_fwd_d;
  logic [31:0] m_cnt;

  always @(negedge clk) begin
    bit          c, e_we, e_stall;
    logic [4:0]  ca;
    logic [31:0] cd;
    if (!rst_n) begin
      chk("rst_we", 32'(rf_we_o), 32'd0);
      chk("rst_stall", 32'(stall_o), 32'd0);
      chk("rst_fwd_valid", 32'(fwd_valid_o), 32'd0);
      chk("rst_instret", instret_o, 32'd0);
      m_pend = 0; m_fwd_v = 0; m_fwd_a = '0; m_fwd_d = '0; m_cnt = '0;
    end else begin
      chk("fwd_valid", 32'(fwd_valid_o), 32'(m_fwd_v));
      chk("fwd_addr", 32'(fwd_addr_o), 32'(m_fwd_a));
      chk("fwd_data", fwd_data_o, m_fwd_d);
      chk("instret", instret_o, m_cnt);
      c = 0; e_stall = 0; ca = '0; cd = '0;
      if (m_pend) begin
        if (data_rvalid_i) begin
          c = 1; ca = m_addr; cd = m_extract(m_op, m_lsb, w_data_rdata_i); m_pend = 0;
        end else e_stall = 1;
      end else if (w_is_load_store_i && w_regfile_wr_i) begin
        if (data_rvalid_i) begin
          c = 1; ca = w_regfile_waddr_i;
          cd = m_extract(w_LOAD_op_i, w_addr_lsb_i, w_data_rdata_i);
        end else begin
          m_pend = 1; m_addr = w_regfile_waddr_i; m_op = w_LOAD_op_i; m_lsb = w_addr_lsb_i;
          e_stall = 1;
        end
      end else if (w_regfile_wr_i) begin
        c = 1; ca = w_regfile_waddr_i; cd = w_regfile_rd_i;
      end
      e_we = c && (ca != 5'd0);
      chk("stall", 32'(stall_o), 32'(e_stall));
      chk("we", 32'(rf_we_o), 32'(e_we));
      if (e_we) begin
        chk("waddr", 32'(rf_waddr_o), 32'(ca));
        chk("wdata", rf_wdata_o, cd);
        m_fwd_v = 1; m_fwd_a = ca; m_fwd_d = cd; m_cnt = m_cnt + 1;
      end
    end
  end

  task automatic drive(input logic [4:0] a, input logic [31:0] rd, input logic wr,
                       input logic ls, input logic [2:0] op, input logic [1:0] lsb,
                       input logic [31:0] rdata, input logic rv);
    @(posedge clk);
    #1;
    w_regfile_waddr_i = a;  w_regfile_rd_i = rd;  w_regfile_wr_i = wr;
    w_is_load_store_i = ls; w_LOAD_op_i = op;     w_addr_lsb_i = lsb;
    w_data_rdata_i = rdata; data_rvalid_i = rv;
  endtask

  task automatic idle();
    drive(5'd0, 32'h0, 1'b0, 1'b0, 3'd0, 2'd0, 32'h0, 1'b0);
  endtask

  initial begin
    int stalls, writes;
    rst_n = 1'b0;
    w_regfile_waddr_i = '0; w_regfile_rd_i = '0; w_regfile_wr_i = 1'b0;
    w_is_load_store_i = 1'b0; w_LOAD_op_i = '0; w_addr_lsb_i = '0;
    w_data_rdata_i = '0; data_rvalid_i = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    chk("reset_waddr", 32'(rf_waddr_o), 32'd0);
    chk("reset_wdata", rf_wdata_o, 32'd0);
    chk("reset_fwd_addr", 32'(fwd_addr_o), 32'd0);
    chk("reset_fwd_data", fwd_data_o, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    drive(5'd5, 32'h1234_5678, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0, 1'b0);
    #2 chk("alu_we", 32'(rf_we_o), 32'd1);
    chk("alu_wdata", rf_wdata_o, 32'h1234_5678);
    idle();
    #2 chk("alu_fwd_addr", 32'(fwd_addr_o), 32'd5);
    chk("alu_fwd_data", fwd_data_o, 32'h1234_5678);
    chk("alu_instret", instret_o, 32'd1);

    drive(5'd6, 32'hDEAD_0000, 1'b1, 1'b1, 3'b000, 2'd3, 32'h80FF_0000, 1'b1);
    #2 chk("lb_wdata", rf_wdata_o, 32'hFFFF_FF80);
    chk("lb_stall", 32'(stall_o), 32'd0);
    drive(5'd7, 32'hDEAD_0000, 1'b1, 1'b1, 3'b100, 2'd3, 32'h80FF_0000, 1'b1);
    #2 chk("lbu_wdata", rf_wdata_o, 32'h0000_0080);
    idle();
    #2 chk("lb_instret", instret_o, 32'd3);

    // LH with rvalid three cycles late; a load presented during WAIT must be ignored
    stalls = 0; writes = 0;
    drive(5'd8, 32'h0, 1'b1, 1'b1, 3'b001, 2'd2, 32'h0, 1'b0);
    #2 stalls += int'(stall_o); writes += int'(rf_we_o);
    for (int i = 0; i < 2; i++) begin
      drive(5'd9, 32'hAAAA_AAAA, 1'b1, 1'b1, 3'b000, 2'd0, 32'h5555_5555, 1'b0);
      #2 stalls += int'(stall_o); writes += int'(rf_we_o);
    end
    drive(5'd9, 32'hAAAA_AAAA, 1'b1, 1'b1, 3'b000, 2'd0, 32'h8001_7FFF, 1'b1);
    #2 chk("lh_stall_drop", 32'(stall_o), 32'd0);
    chk("lh_we", 32'(rf_we_o), 32'd1);
    chk("lh_waddr", 32'(rf_waddr_o), 32'd8);
    chk("lh_wdata", rf_wdata_o, 32'hFFFF_8001);
    chk("lh_stall_cycles", 32'(stalls), 32'd3);
    chk("lh_early_writes", 32'(writes), 32'd0);

    drive(5'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0, 1'b0);
    #2 chk("x0_alu_we", 32'(rf_we_o), 32'd0);
    drive(5'd0, 32'h0, 1'b1, 1'b1, 3'b010, 2'd0, 32'h1111_1111, 1'b1);
    #2 chk("x0_load_we", 32'(rf_we_o), 32'd0);
    idle();
    #2 chk("x0_instret", instret_o, 32'd4);
    chk("x0_fwd_addr", 32'(fwd_addr_o), 32'd8);

    for (int i = 0; i < 3; i++) begin
      drive(5'd3, 32'h0, 1'b0, 1'b1, 3'b010, 2'd0, 32'hCAFE_F00D, 1'(i % 2 == 0));
      #2 chk("store_we", 32'(rf_we_o), 32'd0);
      chk("store_stall", 32'(stall_o), 32'd0);
    end
    drive(5'd4, 32'h0, 1'b0, 1'b0, 3'd0, 2'd0, 32'h0, 1'b1);

    // Back-to-back loads, including one right after a late commit
    drive(5'd10, 32'h0, 1'b1, 1'b1, 3'b010, 2'd1, 32'hDEAD_BEEF, 1'b1);
    #2 chk("lw_wdata", rf_wdata_o, 32'hDEAD_BEEF);
    drive(5'd11, 32'h0, 1'b1, 1'b1, 3'b101, 2'd3, 32'h9ABC_1234, 1'b1);
    #2 chk("lhu_wdata", rf_wdata_o, 32'h0000_9ABC);
    drive(5'd12, 32'h0, 1'b1, 1'b1, 3'b011, 2'd2, 32'h0, 1'b0);
    #2 chk("op011_stall", 32'(stall_o), 32'd1);
    drive(5'd12, 32'h0, 1'b1, 1'b1, 3'b011, 2'd2, 32'h0BAD_CAFE, 1'b1);
    #2 chk("op011_wdata", rf_wdata_o, 32'h0BAD_CAFE);
    drive(5'd13, 32'h0, 1'b1, 1'b1, 3'b000, 2'd1, 32'h0000_7F00, 1'b1);
    #2 chk("b2b_lb_wdata", rf_wdata_o, 32'h0000_007F);
    chk("b2b_lb_stall", 32'(stall_o), 32'd0);
    idle();
    #2 chk("b2b_instret", instret_o, 32'd8);

    // Reset while waiting aborts the load
    drive(5'd14, 32'h0, 1'b1, 1'b1, 3'b010, 2'd0, 32'h0, 1'b0);
    idle();
    #2 chk("wait_stall", 32'(stall_o), 32'd1);
    rst_n = 1'b0;
    #1 chk("abort_stall", 32'(stall_o), 32'd0);
    chk("abort_we", 32'(rf_we_o), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    data_rvalid_i = 1'b1; w_data_rdata_i = 32'h7777_7777;
    #2 chk("late_rvalid_we", 32'(rf_we_o), 32'd0);
    chk("late_rvalid_stall", 32'(stall_o), 32'd0);
    idle();
    #2 chk("abort_instret", instret_o, 32'd0);
    chk("abort_fwd_valid", 32'(fwd_valid_o), 32'd0);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
